// File: rtl/graph_exp_stream_fp16_if.sv
// graph_exp_stream_fp16_if: element, ROM and result stream signals of graph_exp_stream_fp16
//   in_valid/in_data/in_ready     : FP16 element stream into the block
//   lut_addr/lut_data             : EXP ROM address out, registered ROM data back
//   out_valid/out_data/out_ready/out_last : FP16 result stream out of the block
//   slave = the block, master = its environment
interface graph_exp_stream_fp16_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [7:0]  lut_addr;
  logic [15:0] lut_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        out_last;
  modport slave (
    input  in_valid, in_data, lut_data, out_ready,
    output in_ready, lut_addr, out_valid, out_data, out_last
  );
  modport master (
    output in_valid, in_data, lut_data, out_ready,
    input  in_ready, lut_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/graph_exp_stream_fp16.sv
// graph_exp_stream_fp16: streams a len-element FP16 tensor through the 1-cycle EXP ROM with an in-order result FIFO
//   clk, rst_n (async, active low); start/len launch a job; busy high in RUN; done pulses at job end
//   io (slave): element stream in, ROM address/data, result stream out with out_last
module graph_exp_stream_fp16 #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  graph_exp_stream_fp16_if.slave io
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]       state;
  logic [CNT_W-1:0] len_q, in_cnt, out_cnt;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    occ;
  logic             pend;
  logic [15:0]      mem [FIFO_DEPTH];
  logic             in_fire, out_fire, out_end;
  logic             unused_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  // credit counts the element already in the ROM pipeline so the FIFO can never overflow
  assign io.in_ready  = state == RUN && in_cnt < len_q &&
                        ({1'b0, occ} + (OW+1)'(pend)) < (OW+1)'(FIFO_DEPTH);
  assign in_fire      = io.in_valid && io.in_ready;
  assign io.lut_addr  = io.in_data[15:8];
  assign io.out_valid = occ != '0;
  assign io.out_data  = io.out_valid ? mem[rd_ptr] : '0;
  assign out_end      = out_cnt == len_q - CNT_W'(1);
  assign io.out_last  = io.out_valid && out_end;
  assign out_fire     = io.out_valid && io.out_ready;
  assign busy         = state == RUN;
  assign done         = state == FIN;
  assign unused_ok    = &{1'b0, io.in_data[7:0]};
  always_ff @(posedge clk) if (pend) mem[wr_ptr] <= io.lut_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      pend    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      pend <= in_fire;
      occ  <= occ + OW'(pend) - OW'(out_fire);
      if (pend) wr_ptr <= nxt(wr_ptr);
      if (in_fire) in_cnt <= in_cnt + CNT_W'(1);
      if (out_fire) begin
        rd_ptr  <= nxt(rd_ptr);
        out_cnt <= out_cnt + CNT_W'(1);
      end
      if (state == IDLE && start) begin
        len_q   <= len;
        in_cnt  <= '0;
        out_cnt <= '0;
        state   <= len != '0 ? RUN : FIN;
      end else if (state == RUN && out_fire && out_end) state <= FIN;
      else if (state == FIN) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_graph_exp_stream_fp16.sv
// tb_graph_exp_stream_fp16: scoreboard bench for graph_exp_stream_fp16 with a behavioural EXP ROM attached
module tb_graph_exp_stream_fp16;
  localparam int CNT_W = 16;
  typedef struct { logic [15:0] d; logic l; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done;
  logic [CNT_W-1:0] len = '0;
  graph_exp_stream_fp16_if bus();
  graph_exp_stream_fp16 #(.CNT_W(CNT_W), .FIFO_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done), .io(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int acc_cnt = 0, pop_cnt = 0, done_cnt = 0, done_cyc = -1;
  int first_acc = -1, first_valid = -1, first_pop = -1, last_pop = -1;
  int rdy_mode = 0;
  bit vld_rand = 0;
  logic [15:0] stim[$];
  exp_t        sb[$];
  logic [15:0] outs[$];
  logic [15:0] rom_tab [256];
  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
    else for (int i = 0; i < -e; i++) p = p / 2.0;
    return p;
  endfunction
  // exp() of the FP16 value whose upper byte is a (lower byte zero), rounded to FP16
  function automatic logic [15:0] rom_of(input logic [7:0] a);
    int  ex = int'(a[6:2]);
    real m  = real'(int'(a[1:0])) / 4.0;
    real x, y;
    int  e, r;
    if (ex == 31) return (a[1:0] != 2'b00) ? 16'h7E00 : (a[7] ? 16'h0000 : 16'h7C00);
    x = (ex == 0) ? m * pow2(-14) : (1.0 + m) * pow2(ex - 15);
    if (a[7]) x = -x;
    y = $exp(x);
    if (y >= 65520.0) return 16'h7C00;
    e = 15;
    while (e > -14 && y < pow2(e)) e--;
    r = $rtoi(y / pow2(e) * 1024.0 + 0.5);
    return 16'((e + 15) * 1024 + r - 1024);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.lut_data <= rom_tab[bus.lut_addr];
  always @(negedge clk) if (done) begin
    done_cnt <= done_cnt + 1;
    done_cyc <= cyc;
  end
  // driver: presents queued elements, records each accept and its expected result
  initial begin
    exp_t e;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      bus.in_valid = stim.size() != 0 ? (vld_rand ? 1'($urandom_range(0, 1)) : 1'b1)
                                      : 1'($urandom_range(0, 1));
      bus.in_data  = stim.size() != 0 ? stim[0] : 16'($urandom);
      #1;
      if (stim.size() == 0) check("accept_beyond_job", rst_n && bus.in_valid && bus.in_ready, 0);
      else if (rst_n && bus.in_valid && bus.in_ready) begin
        e.d = rom_tab[stim[0][15:8]];
        e.l = stim.size() == 1;
        sb.push_back(e);
        stim.pop_front();
        if (first_acc < 0) first_acc = cyc;
        acc_cnt++;
      end
    end
  end
  // monitor: pops the scoreboard on every output handshake
  initial begin
    bit          prev_stall = 0;
    logic [15:0] prev_d = '0;
    exp_t        e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("out_valid_hold", bus.out_valid, 1);
          check("out_data_hold", bus.out_data, prev_d);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d     = bus.out_data;
        check("occupancy_le_3", (acc_cnt - pop_cnt) <= 3, 1);
        if (!bus.out_valid) check("last_without_valid", bus.out_last, 0);
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
        if (bus.out_valid && bus.out_ready) begin
          check("output_has_input", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_data", bus.out_data, e.d);
            check("out_last", bus.out_last, e.l);
          end
          outs.push_back(bus.out_data);
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          pop_cnt++;
        end
      end
    end
  end
  task automatic launch(input int l);
    first_acc = -1; first_valid = -1; first_pop = -1;
    outs.delete();
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int limit, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < limit) begin
      @(negedge clk); #2;
      k++;
    end
  endtask
  task automatic wait_acc(input int a0, input int n);
    int k = 0;
    while (acc_cnt - a0 < n && k < 50) begin
      @(negedge clk); #2;
      k++;
    end
  endtask
  initial begin
    int d0, p0, a0;
    bit seen;
    logic [15:0] t1_exp [4];
    for (int i = 0; i < 256; i++) rom_tab[i] = rom_of(8'(i));
    t1_exp = '{16'h4170, 16'h35E3, 16'h3C00, 16'h7C00};
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", {bus.out_valid, bus.in_ready, busy, done, bus.out_last, bus.out_data}, 0);
    rst_n = 1'b1;
    // basic job, continuous handshake
    stim = '{16'h3C00, 16'hBC00, 16'h0000, 16'h7C00};
    d0 = done_cnt; p0 = pop_cnt;
    launch(4);
    check("t1_busy", busy, 1);
    wait_done(50, d0);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_outputs", pop_cnt - p0, 4);
    for (int i = 0; i < 4; i++) check("t1_value", outs.size() > i ? outs[i] : 16'hxxxx, t1_exp[i]);
    check("t1_latency", first_valid - first_acc, 2);
    check("t1_back_to_back", last_pop - first_pop, 3);
    check("t1_done_timing", done_cyc - last_pop, 1);
    check("t1_busy_off", busy, 0);
    // output stall from launch
    stim.delete();
    stim.push_back(16'h3C00);
    for (int i = 0; i < 7; i++) stim.push_back(16'($urandom));
    rdy_mode = 2; a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
    launch(8);
    repeat (5) @(negedge clk);
    #2;
    check("t2_accepts_at_stall", acc_cnt - a0, 3);
    check("t2_in_ready_low", bus.in_ready, 0);
    check("t2_head_valid", bus.out_valid, 1);
    check("t2_head_data", bus.out_data, 16'h4170);
    rdy_mode = 0;
    wait_done(100, d0);
    check("t2_outputs", pop_cnt - p0, 8);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_sb_drained", sb.size(), 0);
    // zero-length job
    d0 = done_cnt; seen = 0;
    launch(0);
    #2;
    check("t3_done_next", done, 1);
    repeat (5) begin
      seen = seen | bus.out_valid | bus.in_ready | busy;
      @(negedge clk); #2;
    end
    check("t3_quiet", seen, 0);
    check("t3_done_count", done_cnt - d0, 1);
    // start ignored mid-job
    for (int i = 0; i < 5; i++) stim.push_back(16'($urandom));
    a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
    launch(5);
    wait_acc(a0, 2);
    start = 1'b1;
    len   = CNT_W'(9);
    @(negedge clk);
    start = 1'b0;
    wait_done(100, d0);
    repeat (10) @(negedge clk);
    #2;
    check("t4_outputs", pop_cnt - p0, 5);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_busy_off", busy, 0);
    // randomised handshakes over a long job
    for (int i = 0; i < 100; i++) stim.push_back(16'h3800 + 16'(i));
    vld_rand = 1; rdy_mode = 1; p0 = pop_cnt; d0 = done_cnt;
    launch(100);
    wait_done(2000, d0);
    check("t5_outputs", pop_cnt - p0, 100);
    check("t5_done_count", done_cnt - d0, 1);
    check("t5_sb_drained", sb.size(), 0);
    vld_rand = 0; rdy_mode = 0;
    // reset in the middle of a job
    for (int i = 0; i < 6; i++) stim.push_back(16'($urandom));
    a0 = acc_cnt;
    launch(6);
    wait_acc(a0, 3);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {bus.out_valid, bus.in_ready, busy, done, bus.out_last, bus.out_data}, 0);
    stim.delete();
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    pop_cnt = acc_cnt;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle", busy, 0);
    for (int i = 0; i < 2; i++) stim.push_back(16'($urandom));
    p0 = pop_cnt; d0 = done_cnt;
    launch(2);
    wait_done(50, d0);
    check("t6_outputs", pop_cnt - p0, 2);
    check("t6_done_count", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/graph_exp_stream_fp16.md
Name: graph_exp_stream_fp16

Overview:
Streaming front/back-end for the FP16 EXP lookup ROM (`graph_exp_lut_fp16`) in the graph activation path.
- Accepts a tensor of `len` FP16 elements over a valid/ready input stream.
- Drives the ROM address with each element's upper byte and absorbs the ROM's 1-cycle registered latency.
- Returns the FP16 exp results in order over a valid/ready output stream, with a `last` marker and a done pulse.
- The ROM is instantiated beside this block: `lut_addr` connects to its `addr`, and its `data_out` connects to `lut_data`.

Parameters:
- CNT_W, 16, width of the element count and internal counters.
- FIFO_DEPTH, 3, result buffer entries; legal values are ≥2, and 3 is required for 1 element/cycle under continuous `out_ready`.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle launch pulse, honoured only in IDLE
- len  in  CNT_W  element count, sampled when `start` is honoured
- busy  out  1  high while in RUN
- done  out  1  single-cycle pulse at job end
- in_valid  in  1  input element valid
- in_data  in  16  FP16 input element
- in_ready  out  1  block accepts `in_data` this cycle
- lut_addr  out  8  ROM address, equal to `in_data[15:8]` (combinational)
- lut_data  in  16  ROM registered output, valid the cycle after the address
- out_valid  out  1  result valid
- out_data  out  16  FP16 exp result
- out_ready  in  1  downstream accepts the result
- out_last  out  1  qualifies the final element of the job

Behaviour:
- Reset, asynchronous on `rst_n`=0:
  - State returns to IDLE.
  - Counters, FIFO pointers, occupancy and `pend` clear to 0.
  - All outputs read 0, including `busy`, `done`, `in_ready`, `out_valid`, `out_last` and `out_data`.
  - An in-flight job is discarded, with no `done` pulse.
- States: IDLE, RUN, FIN.
  - IDLE → RUN on `start` with `len`≠0: latch `len`, clear `in_cnt`/`out_cnt`.
  - IDLE → FIN on `start` with `len`=0: no elements are transferred.
  - RUN → FIN on the output handshake with `out_cnt`=`len`−1.
  - FIN → IDLE after one cycle; `done`=1 only in FIN.
  - `start` in RUN or FIN is ignored.
- Input handshake:
  - `in_ready` = RUN && (`in_cnt` < `len`) && (`occ` + `pend` < FIFO_DEPTH).
  - `occ` and `pend` are registered values. There is no combinational path from `out_ready` to `in_ready`.
  - A transfer occurs when `in_valid` && `in_ready`; it increments `in_cnt`.
  - The `in_valid` level is ignored outside RUN or once `in_cnt`=`len`.
- ROM timing:
  - `lut_addr` = `in_data[15:8]` always. Only transfer cycles are meaningful.
  - `pend` is a register equal to the previous cycle's input transfer.
  - When `pend`=1, `lut_data` is written into the FIFO at the end of that cycle.
- Result FIFO:
  - Circular buffer, FIFO_DEPTH entries, in-order.
  - Pointers wrap modulo FIFO_DEPTH.
  - `occ` counts entries; a simultaneous write and pop leaves `occ` unchanged.
  - The credit rule guarantees overflow is impossible.
- Output handshake:
  - `out_valid` = (`occ`≠0); `out_data` = FIFO head.
  - `out_last` = `out_valid` && (`out_cnt` = `len`−1).
  - A pop occurs when `out_valid` && `out_ready`; it increments `out_cnt`.
  - `out_data` must stay stable while `out_valid` && !`out_ready`.
- Throughput and latency:
  - Throughput is 1 element/cycle with continuous `in_valid`/`out_ready` and FIFO_DEPTH=3.
  - Latency from input transfer at cycle t is `out_valid` at t+2: ROM read at t+1, FIFO write at end of t+1.
- Width: counters are CNT_W bits. `len` up to 2^CNT_W−1 is supported, with no wrap within a job.
- The block does not interpret FP16 values. Special values pass through exactly as the ROM returns them.

Test Plan:
- Reset, then `start`, `len`=4, inputs 0x3C00, 0xBC00, 0x0000, 0x7C00, continuous valid/ready, real ROM attached:
  - Outputs 0x4170, 0x35E3, 0x3C00, 0x7C00 on consecutive cycles.
  - First `out_valid` 2 cycles after the first accept.
  - `out_last` on the 4th output; `done` pulses the cycle after it.
- `len`=8, `out_ready` held low for 6 cycles from the start:
  - `in_ready` drops after exactly 3 accepts.
  - `out_data` holds 0x4170 stable.
  - After release all 8 results arrive in order, with no loss or duplication.
- `start` with `len`=0: `done`=1 in the next cycle; `out_valid` and `in_ready` never assert; `busy` stays 0.
- `start` asserted mid-job (`len`=5, after 2 elements): ignored; exactly 5 outputs and one `done`.
- Randomised `in_valid` and `out_ready` over `len`=100 (inputs 0x3800–0x3863):
  - Every output equals the ROM model for `in[15:8]`.
  - The FIFO never overflows.
  - `occ` ≤ 3.
- `rst_n` pulsed low for 1 cycle after 3 of 6 elements:
  - All outputs go to 0 immediately.
  - Returns to IDLE with no `done`.
  - A new job with `len`=2 completes normally.
